fb_access_arbiter: RTL and testbench

Arbiter and sequencer for the single-port framebuffer RAM (16 words × 32 bits, one word per pixel row) of the baby-VGA peripheral. Two requesters share the RAM: the CPU bus port (32-bit reads and writes) and the scanout line fetch, which needs each row's word delivered into a line register before that row is displayed. Scanout has strict priority. The block issues every RAM access, routes read data to the correct requester, and flags scanout overruns and deadline misses.

---
 rtl/fb_arb_pkg.sv | 20 ++
 rtl/fb_access_arbiter.sv | 138 +++++++++++++
 tb/tb_fb_access_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_arb_pkg.sv
// Shared types and default sizes for the framebuffer access arbiter.
// Scanout always wins the single RAM port over the CPU.
package fb_arb_pkg;

  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_DEADLINE = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_LINE = 1'b1
  } owner_t;

endpackage

// File: rtl/fb_access_arbiter.sv
// Single-port framebuffer sequencer: grants the RAM to scanout line fetches
// ahead of CPU reads/writes, routes read data, and flags overruns/deadline misses.
module fb_access_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEADLINE = DEF_DEADLINE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_write,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_req_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rdata_valid,
  input  logic              line_req,
  input  logic [ADDR_W-1:0] line_addr,
  output logic [DATA_W-1:0] line_data,
  output logic              line_valid,
  output logic              line_miss,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W  = $clog2(DEADLINE + 1);
  localparam logic [CNT_W-1:0] DL_MAX = CNT_W'(DEADLINE);
  localparam logic [CNT_W-1:0] DL_ONE = CNT_W'(1);

  state_t              state;
  owner_t              owner;
  logic                line_pend;
  logic                line_redo;
  logic [ADDR_W-1:0]   line_addr_q;
  logic [CNT_W-1:0]    dl_cnt;
  logic                line_busy;
  logic                cap_line;
  logic                overrun;
  logic                dl_hit;

  assign line_busy     = (state != IDLE) && (owner == OWN_LINE);
  assign cap_line      = (state == CAPTURE) && (owner == OWN_LINE);
  assign overrun       = line_req && (line_pend || line_busy);
  assign cpu_req_ready = (state == IDLE) && !line_pend && !line_req;

  // The miss fires on the cycle the counter would land on DEADLINE, unless this
  // capture is the one that serves the outstanding request.
  assign dl_hit = line_pend && !line_req && (dl_cnt == DL_MAX - DL_ONE) &&
                  !(cap_line && !line_redo);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      owner           <= OWN_CPU;
      mem_en          <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      cpu_rdata       <= '0;
      cpu_rdata_valid <= 1'b0;
      line_data       <= '0;
      line_valid      <= 1'b0;
    end else begin
      cpu_rdata_valid <= 1'b0;
      line_valid      <= 1'b0;
      case (state)
        IDLE: begin
          if (line_pend || line_req) begin
            owner    <= OWN_LINE;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= line_req ? line_addr : line_addr_q;
            state    <= ISSUE;
          end else if (cpu_req_valid) begin
            owner    <= OWN_CPU;
            mem_en   <= 1'b1;
            mem_we   <= cpu_req_write;
            mem_addr <= cpu_req_addr;
            if (cpu_req_write) mem_wdata <= cpu_wdata;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= mem_we ? IDLE : CAPTURE;
        end
        CAPTURE: begin
          if (owner == OWN_LINE) begin
            line_data  <= mem_rdata;
            line_valid <= 1'b1;
          end else begin
            cpu_rdata       <= mem_rdata;
            cpu_rdata_valid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // line_redo remembers a request that arrived after the in-flight fetch was
  // issued, so that fetch's capture must not retire the pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_pend   <= 1'b0;
      line_redo   <= 1'b0;
      line_addr_q <= '0;
      dl_cnt      <= '0;
      line_miss   <= 1'b0;
    end else begin
      line_miss <= overrun || dl_hit;
      if (line_req) begin
        line_pend   <= 1'b1;
        line_addr_q <= line_addr;
      end else if (cap_line) begin
        line_pend <= line_redo;
      end
      if (cap_line) begin
        line_redo <= 1'b0;
      end else if (line_req && (state == ISSUE) && (owner == OWN_LINE)) begin
        line_redo <= 1'b1;
      end
      if (line_req) begin
        dl_cnt <= DL_ONE;
      end else if (line_pend && (dl_cnt != DL_MAX)) begin
        dl_cnt <= dl_cnt + DL_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Randomized and directed bench for fb_access_arbiter; two instances (DEADLINE 8 and 4)
// share stimulus and are scored against a transaction-level timing/RAM-shadow model.
module tb_fb_access_arbiter;

  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int DL0 = 8;
  localparam int DL1 = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req_valid;
  logic          cpu_req_write;
  logic [AW-1:0] cpu_req_addr;
  logic [DW-1:0] cpu_wdata;
  logic          line_req;
  logic [AW-1:0] line_addr;

  logic [1:0]    rdy, cvld, lvld, miss, men, mwe;
  logic [DW-1:0] crd [2];
  logic [DW-1:0] ldat [2];
  logic [DW-1:0] mwd [2];
  logic [DW-1:0] mrd [2];
  logic [AW-1:0] mad [2];
  logic [DW-1:0] ram [2][16];
  logic          ram_ready = 1'b0;

  typedef struct {
    int          v;
    logic [31:0] d;
  } ev_t;

  ev_t         cpu_q[$];
  ev_t         line_q[$];
  logic [31:0] shadow [16];
  int          cyc = 0;
  int          idle_at = 0;
  int          lv_last = -1;
  int          ls_last = -1;
  int          ovr_at = -1;
  int          dl_at [2];
  int          miss_cnt [2];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  fb_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEADLINE(DL0)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
    .cpu_req_addr(cpu_req_addr), .cpu_wdata(cpu_wdata),
    .cpu_req_ready(rdy[0]), .cpu_rdata(crd[0]), .cpu_rdata_valid(cvld[0]),
    .line_req(line_req), .line_addr(line_addr),
    .line_data(ldat[0]), .line_valid(lvld[0]), .line_miss(miss[0]),
    .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(mad[0]), .mem_wdata(mwd[0]),
    .mem_rdata(mrd[0])
  );

  fb_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEADLINE(DL1)) u_dut4 (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
    .cpu_req_addr(cpu_req_addr), .cpu_wdata(cpu_wdata),
    .cpu_req_ready(rdy[1]), .cpu_rdata(crd[1]), .cpu_rdata_valid(cvld[1]),
    .line_req(line_req), .line_addr(line_addr),
    .line_data(ldat[1]), .line_valid(lvld[1]), .line_miss(miss[1]),
    .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(mad[1]), .mem_wdata(mwd[1]),
    .mem_rdata(mrd[1])
  );

  function automatic logic [31:0] init_word(input int j);
    return 32'hA5A5_0000 ^ (32'(j) * 32'h0101_1357);
  endfunction

  function automatic int dl_lim(input int i);
    return (i == 0) ? DL0 : DL1;
  endfunction

  // Behavioural single-port RAMs, one per instance, read data one cycle after mem_en.
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 16; j++) ram[i][j] <= init_word(j);
      ram_ready <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (men[i]) begin
          if (mwe[i]) ram[i][mad[i]] <= mwd[i];
          else        mrd[i] <= ram[i][mad[i]];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) if (rst === 1'b0 && miss[i] === 1'b1) miss_cnt[i]++;
  end

  // Transaction-level model: arbiter is free from idle_at; a read returns 3 cycles
  // after grant, a write frees the port after 2; line fetches pre-empt the CPU.
  always @(negedge clk) begin
    logic e_rdy, e_cv, e_lv, e_miss;
    int   lim;
    if (cyc == 0) begin
      for (int j = 0; j < 16; j++) shadow[j] = init_word(j);
      miss_cnt[0] = 0;
      miss_cnt[1] = 0;
    end
    if (rst) begin
      cpu_q.delete();
      line_q.delete();
      idle_at  = cyc + 1;
      lv_last  = -1;
      ls_last  = -1;
      ovr_at   = -1;
      dl_at[0] = -1;
      dl_at[1] = -1;
    end else begin
      e_rdy = !line_req && (cyc >= idle_at);
      e_cv  = (cpu_q.size() > 0) && (cpu_q[0].v == cyc);
      e_lv  = (line_q.size() > 0) && (line_q[0].v == cyc);
      for (int i = 0; i < 2; i++) begin
        e_miss = (ovr_at == cyc) || (dl_at[i] == cyc);
        check($sformatf("ready[%0d]@%0d", i, cyc), 32'(rdy[i]), 32'(e_rdy));
        check($sformatf("cpu_vld[%0d]@%0d", i, cyc), 32'(cvld[i]), 32'(e_cv));
        if (e_cv) check($sformatf("cpu_rdata[%0d]@%0d", i, cyc), crd[i], cpu_q[0].d);
        check($sformatf("line_vld[%0d]@%0d", i, cyc), 32'(lvld[i]), 32'(e_lv));
        if (e_lv) check($sformatf("line_data[%0d]@%0d", i, cyc), ldat[i], line_q[0].d);
        check($sformatf("line_miss[%0d]@%0d", i, cyc), 32'(miss[i]), 32'(e_miss));
      end
      if (e_cv) void'(cpu_q.pop_front());
      if (e_lv) void'(line_q.pop_front());
      if (line_req) begin
        if (lv_last > cyc) begin
          ovr_at = cyc + 1;
          if (ls_last >= cyc) begin
            line_q[line_q.size()-1].d = shadow[line_addr];
          end else begin
            ls_last = lv_last;
            lv_last = lv_last + 3;
            line_q.push_back('{lv_last, shadow[line_addr]});
          end
        end else begin
          ls_last = (cyc > idle_at) ? cyc : idle_at;
          lv_last = ls_last + 3;
          line_q.push_back('{lv_last, shadow[line_addr]});
        end
        idle_at = lv_last;
        for (int i = 0; i < 2; i++) begin
          lim = dl_lim(i);
          dl_at[i] = (lv_last > cyc + lim) ? cyc + lim : -1;
        end
      end else if (cpu_req_valid && e_rdy) begin
        if (cpu_req_write) begin
          shadow[cpu_req_addr] = cpu_wdata;
          idle_at = cyc + 2;
        end else begin
          cpu_q.push_back('{cyc + 3, shadow[cpu_req_addr]});
          idle_at = cyc + 3;
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req_valid = 1'b0;
    cpu_req_write = 1'b0;
    cpu_req_addr  = '0;
    cpu_wdata     = '0;
    line_req      = 1'b0;
    line_addr     = '0;
  endtask

  // Waits (bounded) for a cpu_rdata_valid or line_valid pulse on the DEADLINE=8 instance.
  task automatic wait_pulse(input bit is_line, input int start, output int n);
    n = start;
    while (!(is_line ? lvld[0] : cvld[0]) && n < 12) begin
      tick();
      n++;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_mem_en"},    32'(men[0]),  32'd0);
    check({tag, "_mem_we"},    32'(mwe[0]),  32'd0);
    check({tag, "_mem_addr"},  32'(mad[0]),  32'd0);
    check({tag, "_mem_wdata"}, mwd[0],       32'd0);
    check({tag, "_cpu_rdata"}, crd[0],       32'd0);
    check({tag, "_line_data"}, ldat[0],      32'd0);
    check({tag, "_pulses"},    32'({cvld[0], lvld[0], miss[0]}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m0, m1;
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check_zero_outputs("reset");
    check("reset_ready", 32'(rdy[0]), 32'd1);
    repeat (2) tick();

    // CPU write then read of address 3
    cpu_req_valid = 1'b1; cpu_req_write = 1'b1; cpu_req_addr = 4'd3; cpu_wdata = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    check("wr_mem_en", 32'(men[0]), 32'd1);
    check("wr_mem_we", 32'(mwe[0]), 32'd1);
    check("wr_mem_addr", 32'(mad[0]), 32'd3);
    check("wr_mem_wdata", mwd[0], 32'hDEAD_BEEF);
    tick();
    cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_req_addr = 4'd3;
    tick();
    idle_inputs();
    wait_pulse(1'b0, 1, n);
    check("rd_latency", 32'(n), 32'd3);
    check("rd_data", crd[0], 32'hDEAD_BEEF);
    repeat (3) tick();

    // Simultaneous CPU read and line request: scanout first
    cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_req_addr = 4'd9;
    line_req = 1'b1; line_addr = 4'd5;
    #1;
    check("simul_ready", 32'(rdy[0]), 32'd0);
    tick();
    line_req = 1'b0;
    #1;
    check("simul_mem_addr", 32'(mad[0]), 32'd5);
    check("simul_mem_rd", 32'({men[0], mwe[0]}), 32'b10);
    n = 1;
    while (!rdy[0] && n < 12) begin
      tick();
      n++;
    end
    check("simul_cpu_accept", 32'(n), 32'd3);
    tick();
    idle_inputs();
    repeat (5) tick();

    // Line request one cycle after a CPU read is accepted
    m0 = miss_cnt[0];
    m1 = miss_cnt[1];
    cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_req_addr = 4'd1;
    tick();
    idle_inputs();
    line_req = 1'b1; line_addr = 4'd6;
    tick();
    line_req = 1'b0;
    wait_pulse(1'b1, 1, n);
    check("late_line_latency", 32'(n), 32'd5);
    check("late_line_data", ldat[0], shadow[6]);
    repeat (2) tick();
    check("late_miss_dl8", 32'(miss_cnt[0] - m0), 32'd0);
    check("late_miss_dl4", 32'(miss_cnt[1] - m1), 32'd1);
    repeat (2) tick();

    // Overrun: back-to-back line requests
    m0 = miss_cnt[0];
    line_req = 1'b1; line_addr = 4'd2;
    tick();
    line_addr = 4'd7;
    tick();
    idle_inputs();
    repeat (8) tick();
    check("ovr_miss_count", 32'(miss_cnt[0] - m0), 32'd1);
    check("ovr_final_data", ldat[0], shadow[7]);

    // Reset during CAPTURE of a CPU read
    cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_req_addr = 4'd3;
    tick();
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_zero_outputs("midrst");
    repeat (4) tick();

    // Random CPU traffic with a scanout request every 32 cycles
    for (int k = 0; k < 640; k++) begin
      line_req      = (k % 32) == 0;
      line_addr     = 4'($urandom_range(0, 15));
      cpu_req_valid = 1'($urandom_range(0, 1));
      cpu_req_write = 1'($urandom_range(0, 1));
      cpu_req_addr  = 4'($urandom_range(0, 15));
      cpu_wdata     = $urandom;
      tick();
    end
    idle_inputs();
    repeat (12) tick();
    check("drain_cpu_q", 32'(cpu_q.size()), 32'd0);
    check("drain_line_q", 32'(line_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
